// File: rtl/time_set_controller.sv
// ---------------------------------------------------------------------------
// time_set_controller
//
// Input-side companion to the FND time display. Debounces three raw
// push-buttons and runs the hour/min/sec edit FSM. On commit it issues a
// one-cycle load strobe carrying the edited time into the time counter. It
// also exports which field is being edited and a blink phase, so the display
// path can flash that field.
//
// Parameters
//   CLK_HZ       clock frequency in Hz
//   DEBOUNCE_MS  stable time before a button level is accepted
//   BLINK_HZ     blink rate while editing
//   TIMEOUT_S    inactivity abort time (only with TIME_SET_TIMEOUT_EN)
//
// Ports
//   i_clk          in   1  system clock
//   i_reset        in   1  asynchronous, active-low reset
//   i_btn_mode     in   1  raw mode button, active-high, asynchronous
//   i_btn_up       in   1  raw increment button, active-high, asynchronous
//   i_btn_down     in   1  raw decrement button, active-high, asynchronous
//   i_hour         in   6  current hour from the time counter (0..23)
//   i_min          in   6  current minute (0..59)
//   i_sec          in   6  current second (0..59)
//   o_set_hour     out  6  shadow hour being edited / loaded
//   o_set_min      out  6  shadow minute
//   o_set_sec      out  6  shadow second
//   o_load         out  1  1-cycle strobe: counter takes o_set_* this cycle
//   o_edit_active  out  1  high in any EDIT state
//   o_field        out  2  0=none, 1=hour, 2=min, 3=sec
//   o_blink        out  1  blink phase for the edited field
//
// Build option
//   TIME_SET_TIMEOUT_EN : when defined, an EDIT state with no button press
//   for TIMEOUT_S*CLK_HZ cycles drops back to IDLE without loading.
// ---------------------------------------------------------------------------
module time_set_controller #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int BLINK_HZ    = 2,
    parameter int TIMEOUT_S   = 10
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_mode,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic [5:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    output logic [5:0] o_set_hour,
    output logic [5:0] o_set_min,
    output logic [5:0] o_set_sec,
    output logic       o_load,
    output logic       o_edit_active,
    output logic [1:0] o_field,
    output logic       o_blink
);

    localparam int DB_CYC  = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int DB_W    = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam int BL_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int BL_W    = (BL_HALF > 1) ? $clog2(BL_HALF) : 1;

    localparam logic [5:0] HOUR_MAX = 6'd23;
    localparam logic [5:0] MS_MAX   = 6'd59;

    // Refuse parameter sets that would give zero-length debounce, blink or
    // timeout periods.
    if (DB_CYC < 1 || BL_HALF < 1 || TIMEOUT_S < 1) begin : g_param_check
        $error("time_set_controller: illegal parameter set");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EDIT_HOUR = 3'd1,
        EDIT_MIN  = 3'd2,
        EDIT_SEC  = 3'd3,
        COMMIT    = 3'd4
    } state_t;

    // Button index: 0 = mode, 1 = up, 2 = down
    logic [2:0]      btn_raw;
    logic [2:0]      sync_p0;
    logic [2:0]      sync_p1;
    logic [2:0]      db_level;
    logic [2:0]      db_prev;
    logic [2:0]      press_p2;
    logic [DB_W-1:0] db_cnt [3];

    state_t          state;
    logic [BL_W-1:0] blink_cnt;

    logic            press_mode;
    logic            step_up;
    logic            step_dn;

    assign btn_raw = {i_btn_down, i_btn_up, i_btn_mode};

    // Wrap helpers keep every shadow value inside 0..max.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
        return (v >= max) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
        return (v == 6'd0 || v > max) ? max : v - 6'd1;
    endfunction

    function automatic logic [5:0] sanitize(input logic [5:0] v, input logic [5:0] max);
        return (v > max) ? 6'd0 : v;
    endfunction

    // ---- stage p0/p1: two-flop synchroniser --------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- stage p2: stability counter, debounced level, press pulse ---------
    // The counter only runs while the synchronised sample differs from the
    // accepted level; any sample that agrees with the level restarts it, so
    // the level moves only after DB_CYC consecutive equal samples.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            db_level <= '0;
            db_prev  <= '0;
            press_p2 <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_p1[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DB_CYC - 1)) begin
                    db_cnt[i]   <= '0;
                    db_level[i] <= sync_p1[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
            db_prev  <= db_level;
            press_p2 <= db_level & ~db_prev;
        end
    end

    // Mode beats up/down; up and down together cancel each other.
    assign press_mode = press_p2[0];
    assign step_up    = press_p2[1] & ~press_p2[2] & ~press_p2[0];
    assign step_dn    = press_p2[2] & ~press_p2[1] & ~press_p2[0];

`ifdef TIME_SET_TIMEOUT_EN
    localparam longint TO_CYC = longint'(TIMEOUT_S) * longint'(CLK_HZ);
    localparam int     TO_W   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    logic [TO_W-1:0] to_cnt;
`endif

    // ---- stage p3: edit FSM with registered outputs -------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= IDLE;
            o_set_hour    <= '0;
            o_set_min     <= '0;
            o_set_sec     <= '0;
            o_load        <= 1'b0;
            o_edit_active <= 1'b0;
            o_field       <= 2'd0;
            o_blink       <= 1'b0;
            blink_cnt     <= '0;
`ifdef TIME_SET_TIMEOUT_EN
            to_cnt        <= '0;
`endif
        end else begin
            o_load <= 1'b0;
            case (state)
                IDLE: begin
                    o_edit_active <= 1'b0;
                    o_field       <= 2'd0;
                    o_blink       <= 1'b0;
                    blink_cnt     <= '0;
                    if (press_mode) begin
                        o_set_hour    <= sanitize(i_hour, HOUR_MAX);
                        o_set_min     <= sanitize(i_min, MS_MAX);
                        o_set_sec     <= sanitize(i_sec, MS_MAX);
                        state         <= EDIT_HOUR;
                        o_edit_active <= 1'b1;
                        o_field       <= 2'd1;
                        o_blink       <= 1'b1;
`ifdef TIME_SET_TIMEOUT_EN
                        to_cnt        <= '0;
`endif
                    end
                end

                EDIT_HOUR, EDIT_MIN, EDIT_SEC: begin
                    if (press_mode) begin
                        blink_cnt <= '0;
                        o_blink   <= 1'b1;
                        case (state)
                            EDIT_HOUR: begin
                                state   <= EDIT_MIN;
                                o_field <= 2'd2;
                            end
                            EDIT_MIN: begin
                                state   <= EDIT_SEC;
                                o_field <= 2'd3;
                            end
                            default: begin
                                state         <= COMMIT;
                                o_load        <= 1'b1;
                                o_field       <= 2'd0;
                                o_edit_active <= 1'b0;
                                o_blink       <= 1'b0;
                            end
                        endcase
                    end else begin
                        if (step_up || step_dn) begin
                            case (state)
                                EDIT_HOUR: o_set_hour <= step_up ? wrap_inc(o_set_hour, HOUR_MAX)
                                                                 : wrap_dec(o_set_hour, HOUR_MAX);
                                EDIT_MIN:  o_set_min  <= step_up ? wrap_inc(o_set_min, MS_MAX)
                                                                 : wrap_dec(o_set_min, MS_MAX);
                                default:   o_set_sec  <= step_up ? wrap_inc(o_set_sec, MS_MAX)
                                                                 : wrap_dec(o_set_sec, MS_MAX);
                            endcase
                            blink_cnt <= '0;
                            o_blink   <= 1'b1;
                        end else if (blink_cnt == BL_W'(BL_HALF - 1)) begin
                            blink_cnt <= '0;
                            o_blink   <= ~o_blink;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
`ifdef TIME_SET_TIMEOUT_EN
                    // Any press, even a cancelled up+down pair, counts as
                    // activity. The abort assignments come last so they win.
                    if (|press_p2) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TO_W'(TO_CYC - 1)) begin
                        to_cnt        <= '0;
                        state         <= IDLE;
                        o_edit_active <= 1'b0;
                        o_field       <= 2'd0;
                        o_blink       <= 1'b0;
                        blink_cnt     <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end

                COMMIT: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
